bch_decoder: RTL and testbench
==============================

// Module: bch_decoder
// PURPOSE
//  Receive-side counterpart of bch_encoder: BCH(63,51), t=2, GF(2^6), p(x)=x^6+x+1.
//  Accepts a serial 63-bit codeword (c62 first, c62..c12 data, c11..c0 parity).
//  Computes syndromes S1=r(a), S3=r(a^3), then runs a 63-step Chien search.
//  Streams the 51 corrected data bits serially, with error status.
// PARAMETERS
//  N           63  codeword length (only supported value)
//  K           51  data length (only supported value)
//  CORRECT_EN  1   1: flip located bits; 0: detect/flag only, data passed raw
// PORTS
//  clk                input   1   clock; single clock domain
//  rst                input   1   reset; synchronous, active-high
//  valid_in           input   1   upstream bit valid
//  ready_out          output  1   decoder accepts data_in (RECV state only)
//  data_in            input   1   received codeword bit
//  valid_out          output  1   data_out holds a valid decoded bit
//  ready_in           input   1   downstream accepts data_out
//  data_out           output  1   decoded data bit, d50 first
//  data_out_last      output  1   high with the 51st data bit
//  data_out_all       output  51  parallel corrected data, valid while valid_out
//  err_corrected      output  2   number of bits corrected (0..2)
//  err_uncorrectable  output  1   decoding failure detected
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=RECV, bit counter=0, S1=S3=0.
//   valid_out, data_out, data_out_last, err_* and data_out_all all go to 0.
//   ready_out=0 while rst=1, and =1 the cycle after rst drops.
//  Reset mid-operation abandons the codeword; no partial output.
//  RECV: bit accepted on valid_in&&ready_out; valid_in gaps allowed.
//   Each accepted bit is shifted into a 63-bit buffer.
//   S1 <= S1*a ^ b and S3 <= S3*a^3 ^ b (Horner, 6-bit GF mult by constant).
//   The 63rd accept moves to SOLVE; ready_out drops the next cycle.
//  SOLVE (1 cycle) builds sigma'(x) = S1 + S1^2 x + (S3+S1^3) x^2 (division-free).
//   Degree deg: 0 if S1=S3=0; 1 if S1!=0 and S3=S1^3; 2 otherwise.
//   S1=0 && S3!=0 -> uncorrectable.
//  CHIEN (63 cycles, j=62..0): t1 init S1^2*a, t2 init (S3+S1^3)*a^2.
//   Each step: t1*=a, t2*=a^2. Position j is in error iff S1^t1^t2==0.
//   Up to 2 root positions are stored (6-bit each); roots are counted.
//   root count != deg (incl. >2) -> uncorrectable.
//  OUT: valid_out rises 64 edges after the edge accepting c0.
//   err_* and data_out_all are updated on entry and held stable through OUT.
//   data_out is bit j = 62 downward. Bit is flipped iff CORRECT_EN=1, j matches
//   a stored root, and the codeword is not uncorrectable.
//   Transfer on valid_out&&ready_in. data_out is held stable while ready_in=0.
//   After the 51st transfer: valid_out=0, state=RECV, ready_out=1 next cycle.
//   err_corrected = deg when correctable, else 0. Parity-position roots count too.
//   err_* hold their value until the next OUT entry.
//  No input is accepted outside RECV. There is no overlap of receive and output.
// TESTING
//  1 Encode d=51'b011111100000110011101001010100011001001011110100100 with bch_encoder.
//    Decode it -> identical 51 bits out, err_corrected=0, err_uncorrectable=0.
//  2 Same codeword with c40 flipped -> original data, err_corrected=1, uncorr=0.
//  3 Same codeword with c62 and c0 flipped -> original data, err_corrected=2.
//  4 All-zero codeword with c0,c1,c6 flipped (S1=0, S3!=0).
//    -> err_uncorrectable=1, err_corrected=0, 51 zero data bits.
//  5 Case 1 with valid_in 50% gaps and ready_in toggling 1/0.
//    -> exactly 51 transfers, data_out stable when stalled, data_out_last on the 51st only.
//  6 rst pulsed during CHIEN -> valid_out=0, ready_out=1 the cycle after release.
//    A following codeword (case 2) then decodes correctly.

Source files
------------

// File: rtl/bch_decoder_if.sv
// rtl/bch_decoder_if.sv - serial codeword in / decoded data out handshake bundle for bch_decoder
interface bch_decoder_if;
  logic        valid_in;
  logic        ready_out;
  logic        data_in;
  logic        valid_out;
  logic        ready_in;
  logic        data_out;
  logic        data_out_last;
  logic [50:0] data_out_all;
  logic [1:0]  err_corrected;
  logic        err_uncorrectable;

  modport slave (
    input  valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out, data_out_last,
           data_out_all, err_corrected, err_uncorrectable
  );

  modport master (
    output valid_in, data_in, ready_in,
    input  ready_out, valid_out, data_out, data_out_last,
           data_out_all, err_corrected, err_uncorrectable
  );
endinterface

// File: rtl/bch_decoder.sv
// rtl/bch_decoder.sv - BCH(63,51) t=2 serial decoder over GF(2^6), p(x)=x^6+x+1
// Horner syndromes, one-cycle division-free locator, 63-step Chien search, serial output.
module bch_decoder #(
  parameter int N          = 63,
  parameter int K          = 51,
  parameter bit CORRECT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  bch_decoder_if.slave bus
);
  localparam int PAR = N - K;

  localparam logic [1:0] ST_RECV  = 2'd0;
  localparam logic [1:0] ST_SOLVE = 2'd1;
  localparam logic [1:0] ST_CHIEN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  function automatic logic [5:0] mul_a(input logic [5:0] v);
    return {v[4:0], 1'b0} ^ (v[5] ? 6'b000011 : 6'b000000);
  endfunction

  function automatic logic [5:0] mul_a2(input logic [5:0] v);
    return mul_a(mul_a(v));
  endfunction

  function automatic logic [5:0] mul_a3(input logic [5:0] v);
    return mul_a(mul_a(mul_a(v)));
  endfunction

  function automatic logic [5:0] gf_mul(input logic [5:0] x, input logic [5:0] y);
    logic [5:0] acc;
    logic [5:0] p;
    acc = 6'd0;
    p   = x;
    for (int i = 0; i < 6; i++) begin
      if (y[i]) acc = acc ^ p;
      p = mul_a(p);
    end
    return acc;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [62:0] buf_q, buf_d;
  logic [5:0]  s1_q, s1_d;
  logic [5:0]  s3_q, s3_d;
  logic [5:0]  t1_q, t1_d;
  logic [5:0]  t2_q, t2_d;
  logic [1:0]  deg_q, deg_d;
  logic [1:0]  nroots_q, nroots_d;
  logic [5:0]  root0_q, root0_d;
  logic [5:0]  root1_q, root1_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [50:0] all_q, all_d;
  logic [1:0]  corr_q, corr_d;
  logic        unc_q, unc_d;

  logic        accept;
  logic [5:0]  s1_sq, s1_cu, sig2;
  logic        root_hit;
  logic [1:0]  nroots_n;
  logic        unc;
  logic        flip;

  assign accept = bus.valid_in && ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    s1_d     = s1_q;
    s3_d     = s3_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    deg_d    = deg_q;
    nroots_d = nroots_q;
    root0_d  = root0_q;
    root1_d  = root1_q;
    valid_d  = valid_q;
    all_d    = all_q;
    corr_d   = corr_q;
    unc_d    = unc_q;
    s1_sq    = gf_mul(s1_q, s1_q);
    s1_cu    = gf_mul(s1_sq, s1_q);
    sig2     = s3_q ^ s1_cu;
    root_hit = 1'b0;
    nroots_n = nroots_q;
    unc      = 1'b0;
    flip     = 1'b0;

    case (state_q)
      ST_RECV: begin
        if (accept) begin
          buf_d = {buf_q[61:0], bus.data_in};
          s1_d  = mul_a(s1_q)  ^ {5'd0, bus.data_in};
          s3_d  = mul_a3(s3_q) ^ {5'd0, bus.data_in};
          if (cnt_q == 6'd62) begin
            state_d = ST_SOLVE;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      ST_SOLVE: begin
        if (s1_q == 6'd0 && s3_q == 6'd0)  deg_d = 2'd0;
        else if (s1_q != 6'd0 && sig2 == 6'd0) deg_d = 2'd1;
        else                                deg_d = 2'd2;
        t1_d     = mul_a(s1_sq);
        t2_d     = mul_a2(sig2);
        nroots_d = 2'd0;
        cnt_d    = 6'd62;
        state_d  = ST_CHIEN;
      end

      ST_CHIEN: begin
        // An error-free word makes sigma' identically zero, so skip root counting.
        root_hit = (deg_q != 2'd0) && ((s1_q ^ t1_q ^ t2_q) == 6'd0);
        if (root_hit) begin
          if (nroots_q == 2'd0) root0_d = cnt_q;
          if (nroots_q == 2'd1) root1_d = cnt_q;
          if (nroots_q != 2'd3) nroots_n = nroots_q + 2'd1;
        end
        nroots_d = nroots_n;
        t1_d     = mul_a(t1_q);
        t2_d     = mul_a2(t2_q);
        if (cnt_q == 6'd0) begin
          unc = (s1_q == 6'd0 && s3_q != 6'd0) || (nroots_n != deg_q);
          // Roots found on this last step sit at j=0, a parity bit, so stored roots suffice.
          for (int k = 0; k < K; k++) begin
            flip = CORRECT_EN && !unc &&
                   (((nroots_q >= 2'd1) && (root0_q == 6'(k + PAR))) ||
                    ((nroots_q >= 2'd2) && (root1_q == 6'(k + PAR))));
            all_d[k] = buf_q[k + PAR] ^ flip;
          end
          corr_d  = unc ? 2'd0 : deg_q;
          unc_d   = unc;
          valid_d = 1'b1;
          cnt_d   = 6'd50;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      default: begin
        if (bus.ready_in) begin
          if (cnt_q == 6'd0) begin
            valid_d = 1'b0;
            state_d = ST_RECV;
            s1_d    = 6'd0;
            s3_d    = 6'd0;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
    endcase

    ready_d = (state_d == ST_RECV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RECV;
      cnt_q    <= 6'd0;
      buf_q    <= 63'd0;
      s1_q     <= 6'd0;
      s3_q     <= 6'd0;
      t1_q     <= 6'd0;
      t2_q     <= 6'd0;
      deg_q    <= 2'd0;
      nroots_q <= 2'd0;
      root0_q  <= 6'd0;
      root1_q  <= 6'd0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      all_q    <= 51'd0;
      corr_q   <= 2'd0;
      unc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      s1_q     <= s1_d;
      s3_q     <= s3_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      deg_q    <= deg_d;
      nroots_q <= nroots_d;
      root0_q  <= root0_d;
      root1_q  <= root1_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      all_q    <= all_d;
      corr_q   <= corr_d;
      unc_q    <= unc_d;
    end
  end

  assign bus.ready_out         = ready_q;
  assign bus.valid_out         = valid_q;
  assign bus.data_out          = valid_q & all_q[cnt_q];
  assign bus.data_out_last     = valid_q && (cnt_q == 6'd0);
  assign bus.data_out_all      = all_q;
  assign bus.err_corrected     = corr_q;
  assign bus.err_uncorrectable = unc_q;
endmodule

// File: tb/tb_bch_decoder.sv
// tb/tb_bch_decoder.sv - directed self-checking bench for bch_decoder
module tb_bch_decoder;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  bch_decoder_if bus();

  bch_decoder #(.N(63), .K(51), .CORRECT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Systematic encoder: parity = d(x)*x^12 mod g(x), g = x^12+x^10+x^8+x^5+x^4+x^3+1.
  function automatic logic [62:0] encode(input logic [50:0] d);
    logic [11:0] r;
    logic        fb;
    r = 12'd0;
    for (int i = 50; i >= 0; i--) begin
      fb = d[i] ^ r[11];
      r  = {r[10:0], 1'b0};
      if (fb) r = r ^ 12'h539;
    end
    return {d, r};
  endfunction

  task automatic send_cw(input logic [62:0] cw, input bit gaps, output int acc_cyc);
    int i;
    int guard;
    i       = 62;
    guard   = 0;
    acc_cyc = 0;
    while (i >= 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 1) == 0) begin
        bus.valid_in = 1'b0;
      end else begin
        bus.valid_in = 1'b1;
        bus.data_in  = cw[i];
      end
      if (bus.valid_in && bus.ready_out) begin
        if (i == 0) acc_cyc = cyc + 1;
        i--;
      end
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    check("send_done", 64'(i < 0), 64'd1);
  endtask

  task automatic recv_check(input logic [50:0] exp_d, input logic [1:0] exp_c,
                            input logic exp_u, input bit stall, input int acc_cyc);
    int   guard;
    int   k;
    int   xfers;
    logic prev_d;
    bit   prev_stalled;
    guard        = 0;
    k            = 50;
    xfers        = 0;
    prev_d       = 1'b0;
    prev_stalled = 1'b0;
    bus.ready_in = 1'b0;
    while (!bus.valid_out && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("valid_out_seen", 64'(bus.valid_out), 64'd1);
    if (!bus.valid_out) return;
    check("latency", 64'(cyc - acc_cyc), 64'd64);
    check("err_corrected", 64'(bus.err_corrected), 64'(exp_c));
    check("err_uncorrectable", 64'(bus.err_uncorrectable), 64'(exp_u));
    check("data_out_all", 64'(bus.data_out_all), 64'(exp_d));
    guard = 0;
    while (k >= 0 && guard < 1000) begin
      check("valid_out_hold", 64'(bus.valid_out), 64'd1);
      check("data_out", 64'(bus.data_out), 64'(exp_d[k]));
      check("data_out_last", 64'(bus.data_out_last), 64'(k == 0));
      if (prev_stalled) check("stall_stable", 64'(bus.data_out), 64'(prev_d));
      bus.ready_in = stall ? !bus.ready_in : 1'b1;
      prev_stalled = !bus.ready_in;
      prev_d       = bus.data_out;
      if (bus.ready_in) begin
        k--;
        xfers++;
      end
      @(negedge clk);
      guard++;
    end
    bus.ready_in = 1'b0;
    check("xfers", 64'(xfers), 64'd51);
    check("valid_out_done", 64'(bus.valid_out), 64'd0);
    check("ready_out_after", 64'(bus.ready_out), 64'd1);
    check("err_held", 64'(bus.err_corrected), 64'(exp_c));
  endtask

  initial begin
    logic [50:0] d1;
    logic [50:0] zero_d;
    logic [62:0] cw1;
    logic [62:0] cw;
    int          acc;

    checks       = 0;
    failures     = 0;
    d1           = 51'b011111100000110011101001010100011001001011110100100;
    zero_d       = 51'd0;
    cw1          = encode(d1);
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = 1'b0;
    bus.ready_in = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready_out", 64'(bus.ready_out), 64'd0);
    check("rst_valid_out", 64'(bus.valid_out), 64'd0);
    check("rst_data_out", 64'(bus.data_out), 64'd0);
    check("rst_last", 64'(bus.data_out_last), 64'd0);
    check("rst_all", 64'(bus.data_out_all), 64'd0);
    check("rst_corr", 64'(bus.err_corrected), 64'd0);
    check("rst_unc", 64'(bus.err_uncorrectable), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(bus.ready_out), 64'd1);

    // 1: clean codeword
    send_cw(cw1, 1'b0, acc);
    recv_check(d1, 2'd0, 1'b0, 1'b0, acc);

    // 2: single error at c40
    cw = cw1 ^ (63'd1 << 40);
    send_cw(cw, 1'b0, acc);
    recv_check(d1, 2'd1, 1'b0, 1'b0, acc);

    // 3: double error at c62 and c0
    cw = cw1 ^ (63'd1 << 62) ^ 63'd1;
    send_cw(cw, 1'b0, acc);
    recv_check(d1, 2'd2, 1'b0, 1'b0, acc);

    // 4: S1=0, S3!=0 triple error in parity
    cw = 63'h43;
    send_cw(cw, 1'b0, acc);
    recv_check(zero_d, 2'd0, 1'b1, 1'b0, acc);

    // 5: input gaps and output stalls
    send_cw(cw1, 1'b1, acc);
    recv_check(d1, 2'd0, 1'b0, 1'b1, acc);

    // 6: reset during Chien search, then a single-error word
    send_cw(cw1 ^ (63'd1 << 40), 1'b0, acc);
    repeat (10) @(negedge clk);
    check("pre_rst_valid", 64'(bus.valid_out), 64'd0);
    check("pre_rst_ready", 64'(bus.ready_out), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(bus.ready_out), 64'd0);
    check("midrst_valid", 64'(bus.valid_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", 64'(bus.ready_out), 64'd1);
    check("postrst_valid", 64'(bus.valid_out), 64'd0);
    check("postrst_corr", 64'(bus.err_corrected), 64'd0);
    cw = cw1 ^ (63'd1 << 40);
    send_cw(cw, 1'b0, acc);
    recv_check(d1, 2'd1, 1'b0, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
